wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between two requesters: the pipeline WB stage and the multi-cycle multiply/divide unit (MDU).
- Decodes the WB destination register from the pipeline's rt/rd/link select, using the same encoding as the destination mux.
- Buffers MDU results in a 2-entry FIFO.
- Forces a one-cycle pipeline stall when MDU results have been starved for too long.
- Sits between the WB stage, the MDU and the register file.

Parameters:
- STARVE_MAX, 4, consecutive cycles an MDU result may wait ungranted before a forced stall (legal range 1..15).
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pipe_we  in  1  WB stage requests a register write.
- pipe_dst_sel  in  2  destination select: 00 rt, 01 $31, 10 rd, 11 rt.
- pipe_rt  in  5  rt field of the WB instruction.
- pipe_rd  in  5  rd field of the WB instruction.
- pipe_wdata  in  DW  WB write data.
- mdu_valid  in  1  MDU result valid.
- mdu_dst  in  5  MDU destination register.
- mdu_wdata  in  DW  MDU result data.
- mdu_ready  out  1  FIFO can accept (count<2).
- mdu_pending  out  1  FIFO non-empty.
- stall_pipe  out  1  registered; pipeline must hold the WB stage this cycle.
- rf_we  out  1  registered register-file write enable.
- rf_waddr  out  5  registered write address.
- rf_wdata  out  DW  registered write data.

Behaviour:
- Reset (async, immediate): FIFO count=0, pointers=0, wait_cnt=0, state=IDLE, stall_pipe=0, rf_we=0, rf_waddr=0, rf_wdata=0. A reset asserted mid-operation discards buffered MDU results.
- Destination decode is combinational: pipe_dst = rt, 31, rd or rt per pipe_dst_sel. Select 11 is treated as 00.
- pipe_req = pipe_we & (pipe_dst != 0) & ~stall_pipe. A pipeline write to $0 is not a request and frees the slot.
- FIFO:
  - Enqueue when mdu_valid & mdu_ready.
  - An entry is eligible for grant from the cycle after enqueue; there is no bypass.
  - mdu_ready depends only on count, with no same-cycle dequeue credit. When full, mdu_ready=0 and the MDU must hold its result.
  - Simultaneous enqueue and dequeue leave count unchanged.
- Grant priority, evaluated each cycle:
  1. If stall_pipe=1, grant the FIFO head.
  2. Else if pipe_req, grant the pipeline.
  3. Else if the FIFO is non-empty, grant the FIFO head.
  4. Else, no grant.
- An FIFO-head grant always dequeues the head.
- A head with mdu_dst=0 is dequeued but produces rf_we=0.
- Output latency is 1 cycle: on the next edge, rf_we/rf_waddr/rf_wdata are loaded from the granted source. With no grant, rf_we=0 and addr/data hold their previous values.
- Starvation FSM:
  - States: IDLE, WAIT, FORCE.
  - IDLE: go to WAIT when the FIFO is non-empty and the head is not granted; wait_cnt=1.
  - WAIT:
    - Head granted: go to IDLE, wait_cnt=0.
    - Head not granted and wait_cnt==STARVE_MAX: go to FORCE and set stall_pipe=1 (registered).
    - Otherwise: wait_cnt+1.
  - FORCE: the head is granted (priority 1). Next state is IDLE, stall_pipe=0, wait_cnt=0.
  - stall_pipe is high for exactly one cycle per FORCE entry.
- The WB instruction held during stall_pipe is re-presented the following cycle and wins the port if pipe_req. A remaining FIFO entry restarts counting from IDLE.
- wait_cnt saturates at STARVE_MAX and never wraps.
- mdu_pending = (count != 0).

Test Plan:
- Reset: assert rst asynchronously mid-cycle with 2 FIFO entries -> all outputs 0 immediately, mdu_ready=1, mdu_pending=0.
- Decode: pipe_we=1, rt=5, rd=9, sel=00/01/10/11 on consecutive cycles -> rf_waddr 5, 31, 9, 5 one cycle later, rf_we=1 each.
- Idle slot: enqueue MDU dst=12 data=0xDEADBEEF while pipe_we=0 -> rf_we=1, rf_waddr=12, rf_wdata=0xDEADBEEF two cycles after mdu_valid; pipe_we=1 with dst $0 also leaves the slot to the MDU.
- Full FIFO: three back-to-back mdu_valid with the pipeline writing every cycle -> mdu_ready=0 after two accepts; the third result is held until a dequeue.
- Starvation, STARVE_MAX=4: a continuous pipeline write stream with 1 MDU entry -> stall_pipe=1 for exactly one cycle at the 5th ungranted cycle. The MDU entry is written in that slot, and the held pipeline write is written in the next slot.
- MDU dst=0: the entry is dequeued, rf_we stays 0, and mdu_pending drops.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the WB stage and the MDU.
// MDU results are buffered in a 2-entry FIFO; a starvation FSM forces a one-cycle pipeline stall.
`default_nettype none

module wb_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_we,
    input  logic [1:0]    pipe_dst_sel,
    input  logic [4:0]    pipe_rt,
    input  logic [4:0]    pipe_rd,
    input  logic [DW-1:0] pipe_wdata,
    input  logic          mdu_valid,
    input  logic [4:0]    mdu_dst,
    input  logic [DW-1:0] mdu_wdata,
    output logic          mdu_ready,
    output logic          mdu_pending,
    output logic          stall_pipe,
    output logic          rf_we,
    output logic [4:0]    rf_waddr,
    output logic [DW-1:0] rf_wdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t        state;
    logic [3:0]    wait_cnt;
    logic [4:0]    fifo_dst  [2];
    logic [DW-1:0] fifo_data [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;

    logic [4:0]    pipe_dst;
    logic          pipe_req;
    logic          fifo_nonempty;
    logic          enq;
    logic          grant_fifo;
    logic [4:0]    head_dst;
    logic [DW-1:0] head_data;

    always_comb begin
        pipe_dst = pipe_rt;
        case (pipe_dst_sel)
            2'b01:   pipe_dst = 5'd31;
            2'b10:   pipe_dst = pipe_rd;
            default: pipe_dst = pipe_rt;
        endcase
    end

    assign fifo_nonempty = (count != 2'd0);
    assign mdu_pending   = fifo_nonempty;
    assign mdu_ready     = (count < 2'd2);
    assign enq           = mdu_valid & mdu_ready;
    assign pipe_req      = pipe_we & (pipe_dst != 5'd0) & ~stall_pipe;
    // pipe_req is already masked by stall_pipe, so a forced stall always reaches the FIFO head.
    assign grant_fifo    = fifo_nonempty & ~pipe_req;
    assign head_dst      = fifo_dst[rd_ptr];
    assign head_data     = fifo_data[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
            fifo_dst[0]  <= 5'd0;
            fifo_dst[1]  <= 5'd0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
        end else begin
            if (enq) begin
                fifo_dst[wr_ptr]  <= mdu_dst;
                fifo_data[wr_ptr] <= mdu_wdata;
                wr_ptr            <= ~wr_ptr;
            end
            if (grant_fifo) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({enq, grant_fifo})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= '0;
        end else if (pipe_req) begin
            rf_we    <= 1'b1;
            rf_waddr <= pipe_dst;
            rf_wdata <= pipe_wdata;
        end else if (grant_fifo && head_dst != 5'd0) begin
            rf_we    <= 1'b1;
            rf_waddr <= head_dst;
            rf_wdata <= head_data;
        end else begin
            // A $0 head is dropped like an idle slot: address and data hold.
            rf_we <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            stall_pipe <= 1'b0;
        end else begin
            stall_pipe <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fifo_nonempty && !grant_fifo) begin
                        state    <= S_WAIT;
                        wait_cnt <= 4'd1;
                    end else begin
                        wait_cnt <= 4'd0;
                    end
                end
                S_WAIT: begin
                    if (grant_fifo) begin
                        state    <= S_IDLE;
                        wait_cnt <= 4'd0;
                    end else if (wait_cnt >= STARVE_LIM) begin
                        state      <= S_FORCE;
                        stall_pipe <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_FORCE: begin
                    state    <= S_IDLE;
                    wait_cnt <= 4'd0;
                end
                default: begin
                    state    <= S_IDLE;
                    wait_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed stimulus with a write scoreboard and a status-expectation queue,
// both drained by a negedge monitor.
`default_nettype none

module tb_wb_port_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          pipe_we;
    logic [1:0]    pipe_dst_sel;
    logic [4:0]    pipe_rt;
    logic [4:0]    pipe_rd;
    logic [DW-1:0] pipe_wdata;
    logic          mdu_valid;
    logic [4:0]    mdu_dst;
    logic [DW-1:0] mdu_wdata;
    logic          mdu_ready;
    logic          mdu_pending;
    logic          stall_pipe;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;

    wb_port_arbiter #(.STARVE_MAX(4), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_we      (pipe_we),
        .pipe_dst_sel (pipe_dst_sel),
        .pipe_rt      (pipe_rt),
        .pipe_rd      (pipe_rd),
        .pipe_wdata   (pipe_wdata),
        .mdu_valid    (mdu_valid),
        .mdu_dst      (mdu_dst),
        .mdu_wdata    (mdu_wdata),
        .mdu_ready    (mdu_ready),
        .mdu_pending  (mdu_pending),
        .stall_pipe   (stall_pipe),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       name;
    } st_t;

    localparam int SIG_WE = 0, SIG_ADDR = 1, SIG_DATA = 2, SIG_STALL = 3, SIG_READY = 4, SIG_PEND = 5;

    wr_t wq[$];
    st_t sq[$];
    int  tests = 0;
    int  fails = 0;
    bit  done = 1'b0;
    bit  end_chk = 1'b0;

    wr_t         w_item;
    st_t         s_item;
    logic [31:0] act;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void exp_wr(int dc, logic [4:0] a, logic [31:0] d);
        wr_t w;
        w.cyc = cyc + dc; w.addr = a; w.data = d;
        wq.push_back(w);
    endfunction

    function automatic void exp_st(int dc, int sig, logic [31:0] v, string nm);
        st_t s;
        s.cyc = cyc + dc; s.sig = sig; s.val = v; s.name = nm;
        sq.push_back(s);
    endfunction

    always @(negedge clk) begin
        while (sq.size() > 0 && sq[0].cyc <= cyc) begin
            s_item = sq.pop_front();
            case (s_item.sig)
                SIG_WE:    act = 32'(rf_we);
                SIG_ADDR:  act = 32'(rf_waddr);
                SIG_DATA:  act = rf_wdata;
                SIG_STALL: act = 32'(stall_pipe);
                SIG_READY: act = 32'(mdu_ready);
                default:   act = 32'(mdu_pending);
            endcase
            tests++;
            if (s_item.cyc != cyc || act !== s_item.val) begin
                fails++;
                $display("FAIL %s: got %0h expected %0h (cycle %0d, due %0d)",
                         s_item.name, act, s_item.val, cyc, s_item.cyc);
            end
        end
        if (!rst) begin
            if (rf_we) begin
                tests++;
                if (wq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write: got addr %0d data %0h at cycle %0d, expected none",
                             rf_waddr, rf_wdata, cyc);
                end else begin
                    w_item = wq.pop_front();
                    if (w_item.cyc != cyc || rf_waddr !== w_item.addr || rf_wdata !== w_item.data) begin
                        fails++;
                        $display("FAIL rf_write: got cycle %0d addr %0d data %0h, expected cycle %0d addr %0d data %0h",
                                 cyc, rf_waddr, rf_wdata, w_item.cyc, w_item.addr, w_item.data);
                    end
                end
            end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
                w_item = wq.pop_front();
                tests++;
                fails++;
                $display("FAIL missed_write: got rf_we 0 at cycle %0d, expected addr %0d data %0h",
                         cyc, w_item.addr, w_item.data);
            end
        end
        if (done && !end_chk) begin
            end_chk = 1'b1;
            tests++;
            if (wq.size() != 0 || sq.size() != 0) begin
                fails++;
                $display("FAIL drain: got %0d writes and %0d status checks outstanding, expected 0",
                         wq.size(), sq.size());
            end
        end
    end

    logic [4:0] dec_exp [4];

    initial begin
        rst = 1'b1;
        pipe_we = 0; pipe_dst_sel = 0; pipe_rt = 0; pipe_rd = 0; pipe_wdata = 0;
        mdu_valid = 0; mdu_dst = 0; mdu_wdata = 0;
        dec_exp[0] = 5'd5; dec_exp[1] = 5'd31; dec_exp[2] = 5'd9; dec_exp[3] = 5'd5;

        // Reset state
        tick();
        exp_st(0, SIG_WE, 0, "reset_rf_we");
        exp_st(0, SIG_ADDR, 0, "reset_rf_waddr");
        exp_st(0, SIG_DATA, 0, "reset_rf_wdata");
        exp_st(0, SIG_STALL, 0, "reset_stall");
        exp_st(0, SIG_READY, 1, "reset_ready");
        exp_st(0, SIG_PEND, 0, "reset_pending");
        tick();
        rst = 1'b0;
        tick();

        // Destination decode
        pipe_we = 1; pipe_rt = 5'd5; pipe_rd = 5'd9;
        for (int i = 0; i < 4; i++) begin
            pipe_dst_sel = 2'(i);
            pipe_wdata   = 32'hA000_0000 + 32'(i);
            exp_wr(1, dec_exp[i], pipe_wdata);
            tick();
        end
        pipe_we = 0;
        tick();

        // Idle slot goes to the MDU, also when the pipeline writes $0
        mdu_valid = 1; mdu_dst = 5'd12; mdu_wdata = 32'hDEAD_BEEF;
        exp_wr(2, 5'd12, 32'hDEAD_BEEF);
        tick();
        mdu_valid = 0;
        tick(); tick();
        pipe_we = 1; pipe_dst_sel = 2'b00; pipe_rt = 5'd0; pipe_wdata = 32'h1234_5678;
        mdu_valid = 1; mdu_dst = 5'd7; mdu_wdata = 32'h0BAD_F00D;
        exp_wr(2, 5'd7, 32'h0BAD_F00D);
        tick();
        mdu_valid = 0;
        tick();
        pipe_we = 0;
        tick();

        // Full FIFO: pipeline busy N0..N3, three MDU results back to back
        exp_wr(1, 5'd3, 32'hB0);
        exp_wr(2, 5'd3, 32'hB1);
        exp_wr(3, 5'd3, 32'hB2);
        exp_wr(4, 5'd3, 32'hB3);
        exp_wr(5, 5'd20, 32'hC0);
        exp_wr(6, 5'd21, 32'hC1);
        exp_wr(7, 5'd22, 32'hC2);
        exp_st(2, SIG_READY, 0, "full_ready_n2");
        exp_st(4, SIG_READY, 0, "full_ready_n4");
        exp_st(5, SIG_READY, 1, "full_ready_n5");
        pipe_we = 1; pipe_rt = 5'd3; pipe_wdata = 32'hB0;
        mdu_valid = 1; mdu_dst = 5'd20; mdu_wdata = 32'hC0;
        tick();
        pipe_wdata = 32'hB1; mdu_dst = 5'd21; mdu_wdata = 32'hC1;
        tick();
        pipe_wdata = 32'hB2; mdu_dst = 5'd22; mdu_wdata = 32'hC2;
        tick();
        pipe_wdata = 32'hB3;
        tick();
        pipe_we = 0;
        tick();
        tick();
        mdu_valid = 0;
        tick(); tick(); tick();

        // Starvation with STARVE_MAX=4
        for (int k = 0; k < 6; k++) exp_wr(k + 1, 5'd4, 32'hD0 + 32'(k));
        exp_wr(7, 5'd25, 32'hE0);
        exp_wr(8, 5'd4, 32'hD6);
        exp_wr(9, 5'd4, 32'hD7);
        exp_st(5, SIG_STALL, 0, "starve_stall_pre");
        exp_st(6, SIG_STALL, 1, "starve_stall_on");
        exp_st(7, SIG_STALL, 0, "starve_stall_off");
        pipe_we = 1; pipe_rt = 5'd4; pipe_wdata = 32'hD0;
        mdu_valid = 1; mdu_dst = 5'd25; mdu_wdata = 32'hE0;
        tick();
        mdu_valid = 0;
        for (int k = 1; k <= 6; k++) begin
            pipe_wdata = 32'hD0 + 32'(k);
            tick();
        end
        pipe_wdata = 32'hD6;
        tick();
        pipe_wdata = 32'hD7;
        tick();
        pipe_we = 0;
        tick(); tick(); tick();

        // MDU result to $0 is dropped
        mdu_valid = 1; mdu_dst = 5'd0; mdu_wdata = 32'hF00;
        exp_st(1, SIG_PEND, 1, "dst0_pending_on");
        exp_st(2, SIG_PEND, 0, "dst0_pending_off");
        exp_st(2, SIG_WE, 0, "dst0_rf_we");
        tick();
        mdu_valid = 0;
        tick(); tick(); tick();

        // Asynchronous reset with two buffered entries
        exp_wr(1, 5'd6, 32'h51);
        exp_wr(2, 5'd6, 32'h52);
        exp_st(2, SIG_READY, 0, "prereset_ready");
        exp_st(2, SIG_PEND, 1, "prereset_pending");
        pipe_we = 1; pipe_rt = 5'd6; pipe_wdata = 32'h51;
        mdu_valid = 1; mdu_dst = 5'd10; mdu_wdata = 32'h61;
        tick();
        pipe_wdata = 32'h52; mdu_dst = 5'd11; mdu_wdata = 32'h62;
        tick();
        mdu_valid = 0; pipe_wdata = 32'h53;
        tick();
        exp_st(0, SIG_WE, 0, "midreset_rf_we");
        exp_st(0, SIG_ADDR, 0, "midreset_rf_waddr");
        exp_st(0, SIG_DATA, 0, "midreset_rf_wdata");
        exp_st(0, SIG_STALL, 0, "midreset_stall");
        exp_st(0, SIG_READY, 1, "midreset_ready");
        exp_st(0, SIG_PEND, 0, "midreset_pending");
        #2;
        rst = 1'b1;
        pipe_we = 0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Recovery after reset
        pipe_we = 1; pipe_dst_sel = 2'b10; pipe_rd = 5'd8; pipe_wdata = 32'h55;
        exp_wr(1, 5'd8, 32'h55);
        tick();
        pipe_we = 0;
        tick(); tick();
        done = 1'b1;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
